// File: rtl/rom_fetch_pkg.sv
// Shared types and default constants for the ROM burst fetcher.
package rom_fetch_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_COLLECT,
      S_FINISH
   } fetch_state_t;

   localparam int DEF_DATA_W    = 32;
   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_RD_LAT    = 2;
   localparam int DEF_BURST_LEN = 1;
   localparam int LAT_W         = 4;

endpackage

// File: rtl/rom_burst_fetch_lat_counter.sv
// Read-latency down-counter: load a start value, decrement to zero, flag zero.
module lat_counter
   import rom_fetch_pkg::*;
#(
   parameter int CNT_W = LAT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/rom_burst_fetch.sv
// Burst fetcher for a fixed-latency ROM with valid/ready output.
// Define ROM_FETCH_WRAP_EN to wrap the address at the end of the ROM instead of stopping.
module rom_burst_fetch
   import rom_fetch_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int ROM_DEPTH = 2**ADDR_W,
   parameter int RD_LAT    = DEF_RD_LAT,
   parameter int BURST_LEN = DEF_BURST_LEN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] rom_data,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_rd,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              finish,
   output logic              end_of_rom
);

   localparam int BEAT_W = $clog2(BURST_LEN + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
   // ISSUE loads RD_LAT-2 so WAIT (which exits on zero) lasts RD_LAT-1 cycles.
   localparam logic [LAT_W-1:0]  LAT_LOAD  = (RD_LAT > 1) ? LAT_W'(RD_LAT - 2) : '0;

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [BEAT_W-1:0] beat_q;
   logic [DATA_W-1:0] data_p1;
   logic              eor_q;
   logic              locked;
   logic              at_last;
   logic              hs;
   logic              end_stop;
   logic              enter_collect;
   logic              lat_load, lat_dec, lat_zero;

   assign at_last = (addr_q == LAST_ADDR);

`ifdef ROM_FETCH_WRAP_EN
   assign locked   = 1'b0;
   assign end_stop = 1'b0;
`else
   assign locked   = eor_q;
   assign end_stop = at_last;
`endif

   lat_counter #(.CNT_W(LAT_W)) u_lat (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (lat_load),
      .dec      (lat_dec),
      .load_val (LAT_LOAD),
      .zero     (lat_zero)
   );

   always_comb begin
      state_d       = state_q;
      lat_load      = 1'b0;
      lat_dec       = 1'b0;
      hs            = 1'b0;
      enter_collect = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !locked) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            lat_load = 1'b1;
            if (RD_LAT == 1) begin
               state_d       = S_COLLECT;
               enter_collect = 1'b1;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            lat_dec = 1'b1;
            if (lat_zero) begin
               state_d       = S_COLLECT;
               enter_collect = 1'b1;
            end
         end
         S_COLLECT: begin
            if (out_ready) begin
               hs      = 1'b1;
               state_d = ((beat_q == LAST_BEAT) || end_stop) ? S_FINISH : S_ISSUE;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q <= '0;
         beat_q <= '0;
         eor_q  <= 1'b0;
      end else begin
`ifdef ROM_FETCH_WRAP_EN
         eor_q <= hs && at_last;
         if (hs) addr_q <= at_last ? '0 : addr_q + 1'b1;
`else
         if (hs && at_last) eor_q <= 1'b1;
         if (hs) addr_q <= addr_q + 1'b1;
`endif
         if (hs) beat_q <= beat_q + 1'b1;
         if (state_q == S_FINISH) beat_q <= '0;
      end
   end

   // Data capture on COLLECT entry; held until the handshake.
   always_ff @(posedge clk) begin
      if (enter_collect) data_p1 <= rom_data;
   end

   assign rom_rd     = (state_q == S_ISSUE);
   assign rom_addr   = rom_rd ? addr_q : '0;
   assign out_valid  = (state_q == S_COLLECT);
   assign out_data   = out_valid ? data_p1 : '0;
   assign busy       = (state_q != S_IDLE);
   assign finish     = (state_q == S_FINISH);
   assign end_of_rom = eor_q;

endmodule

// File: tb/tb_rom_burst_fetch.sv
// Scoreboard bench for rom_burst_fetch: three instances (defaults, 4-beat/RD_LAT=3, depth-4/RD_LAT=1).
module tb_rom_burst_fetch;

   localparam int N = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0] rst_n, start, out_ready;
   wire  [N-1:0] rom_rd, out_valid, busy, finish, eor;
   wire  [15:0]  rom_addr [N];
   wire  [31:0]  rom_data [N];
   wire  [31:0]  out_data [N];

   logic [15:0] u0_a1, u1_a1, u1_a2;

   function automatic logic [31:0] rom_word(input logic [15:0] a);
      return {~a, a};
   endfunction

   function automatic int lat_of(input int i);
      return (i == 0) ? 2 : (i == 1) ? 3 : 1;
   endfunction

   function automatic int depth_of(input int i);
      return (i == 2) ? 4 : 65536;
   endfunction

   // ROM models: RD_LAT-1 address register stages, then a combinational lookup.
   always @(posedge clk) begin
      u0_a1 <= rom_addr[0];
      u1_a1 <= rom_addr[1];
      u1_a2 <= u1_a1;
   end
   assign rom_data[0] = rom_word(u0_a1);
   assign rom_data[1] = rom_word(u1_a2);
   assign rom_data[2] = rom_word(rom_addr[2]);

   rom_burst_fetch #(.RD_LAT(2)) u_def (
      .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .rom_data(rom_data[0]),
      .rom_addr(rom_addr[0]), .rom_rd(rom_rd[0]), .out_data(out_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .busy(busy[0]),
      .finish(finish[0]), .end_of_rom(eor[0]));

   rom_burst_fetch #(.BURST_LEN(4), .RD_LAT(3)) u_b4 (
      .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .rom_data(rom_data[1]),
      .rom_addr(rom_addr[1]), .rom_rd(rom_rd[1]), .out_data(out_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .busy(busy[1]),
      .finish(finish[1]), .end_of_rom(eor[1]));

   rom_burst_fetch #(.ROM_DEPTH(4), .BURST_LEN(6), .RD_LAT(1)) u_r4 (
      .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .rom_data(rom_data[2]),
      .rom_addr(rom_addr[2]), .rom_rd(rom_rd[2]), .out_data(out_data[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .busy(busy[2]),
      .finish(finish[2]), .end_of_rom(eor[2]));

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [15:0] iss_q  [N][$];
   logic [15:0] beat_q [N][$];
   int fin_cnt [N] = '{default: 0};
   int hs_cnt  [N] = '{default: 0};
   int iss_cnt [N] = '{default: 0};
   int eor_cnt [N] = '{default: 0};
   int iss_cyc [N] = '{default: 0};
   int hs_cyc  [N] = '{default: 0};
   int fin_cyc [N] = '{default: 0};
   logic [N-1:0] arm = '0, prev_valid = '0, prev_stall = '0, eor_ev = '0;
   logic [31:0]  prev_data [N];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Output monitor: pops expected issue addresses and beats from the scoreboard.
   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("zero_out%0d", i),
             {(rom_rd[i] ? 16'h0 : rom_addr[i]), (out_valid[i] ? 32'h0 : out_data[i])}, 64'h0);
         if ((rom_rd[i] || out_valid[i] || finish[i]) && !busy[i]) chk("busy_hi", 0, 1);
         if (rom_rd[i]) begin
            iss_cnt[i]++;
            if (arm[i]) begin
               chk("b2b_gap", cyc - fin_cyc[i], 2);
               arm[i] = 1'b0;
            end
            if (iss_q[i].size() == 0) chk($sformatf("unexp_issue%0d", i), rom_addr[i], 64'hffff_ffff);
            else chk($sformatf("issue_addr%0d", i), rom_addr[i], iss_q[i].pop_front());
            iss_cyc[i] = cyc;
         end
         if (out_valid[i] && !prev_valid[i]) chk($sformatf("latency%0d", i), cyc - iss_cyc[i], lat_of(i));
         if (out_valid[i] && prev_stall[i]) chk("stall_hold", out_data[i], prev_data[i]);
         if (eor[i]) begin
            eor_cnt[i]++;
            chk("eor_early", eor_ev[i], 1);
`ifdef ROM_FETCH_WRAP_EN
            eor_ev[i] = 1'b0;
`endif
         end
         if (out_valid[i] && out_ready[i]) begin
            hs_cnt[i]++;
            hs_cyc[i] = cyc;
            if (beat_q[i].size() == 0) chk($sformatf("unexp_beat%0d", i), out_data[i], 64'hffff_ffff_ffff);
            else begin
               logic [15:0] a;
               a = beat_q[i].pop_front();
               chk($sformatf("beat_data%0d", i), out_data[i], rom_word(a));
               if (int'(a) == depth_of(i) - 1) eor_ev[i] = 1'b1;
            end
         end
         if (finish[i]) begin
            fin_cnt[i]++;
            chk("fin_after_beat", cyc - hs_cyc[i], 1);
            arm[i]     = start[i];
            fin_cyc[i] = cyc;
         end
         prev_valid[i] = out_valid[i];
         prev_stall[i] = out_valid[i] && !out_ready[i];
         prev_data[i]  = out_data[i];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int i);
      start[i] = 1'b1;
      tick();
      start[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      int n;
      n = 0;
      while (busy[i] && n < 200) begin
         tick();
         n++;
      end
      if (busy[i]) chk("idle_timeout", 1, 0);
   endtask

   task automatic expect_burst(input int i, input int first, input int cnt);
      for (int k = 0; k < cnt; k++) begin
         iss_q[i].push_back(16'((first + k) % depth_of(i)));
         beat_q[i].push_back(16'((first + k) % depth_of(i)));
      end
   endtask

   initial begin
      int n, seen, f;
      rst_n     = '0;
      start     = '0;
      out_ready = '1;
      repeat (3) tick();
      for (int i = 0; i < N; i++)
         chk("reset_outs", {rom_rd[i], out_valid[i], busy[i], finish[i], eor[i], rom_addr[i], out_data[i]}, 0);
      rst_n = '1;
      tick();

      // Defaults: single-word bursts, then a second start fetches the next address.
      expect_burst(0, 0, 1);
      pulse(0);
      chk("issue_busy", {busy[0], rom_rd[0]}, 2'b11);
      wait_idle(0);
      chk("fin_a", fin_cnt[0], 1);
      expect_burst(0, 1, 1);
      pulse(0);
      wait_idle(0);
      chk("fin_a2", fin_cnt[0], 2);
      chk("beats_a", hs_cnt[0], 2);

      // start held high: back-to-back bursts.
      expect_burst(0, 2, 3);
      start[0] = 1'b1;
      n = 0;
      seen = 0;
      while (seen < 3 && n < 100) begin
         tick();
         n++;
         if (finish[0]) seen++;
      end
      start[0] = 1'b0;
      if (seen < 3) chk("hold_timeout", seen, 3);
      wait_idle(0);
      repeat (3) tick();
      chk("hold_fin", fin_cnt[0], 5);
      chk("hold_iss", iss_cnt[0], 5);

      // 4-beat burst, RD_LAT=3, beat 2 stalled for 5 cycles.
      expect_burst(1, 0, 4);
      pulse(1);
      n = 0;
      while (hs_cnt[1] < 2 && n < 100) begin tick(); n++; end
      out_ready[1] = 1'b0;
      n = 0;
      while (!out_valid[1] && n < 20) begin tick(); n++; end
      chk("stall_valid", out_valid[1], 1);
      repeat (5) tick();
      out_ready[1] = 1'b1;
      wait_idle(1);
      chk("fin_b", fin_cnt[1], 1);
      chk("beats_b", hs_cnt[1], 4);

      // Reset during WAIT of beat 1: abort without finish, restart from address 0.
      f = fin_cnt[1];
      expect_burst(1, 4, 2);
      beat_q[1].pop_back();
      pulse(1);
      n = 0;
      while (hs_cnt[1] < 5 && n < 50) begin tick(); n++; end
      tick();
      chk("in_wait", {rom_rd[1], out_valid[1], busy[1]}, 3'b001);
      rst_n[1] = 1'b0;
      iss_q[1].delete();
      beat_q[1].delete();
      tick();
      chk("abort_outs", {rom_rd[1], out_valid[1], busy[1], finish[1], eor[1], rom_addr[1], out_data[1]}, 0);
      rst_n[1] = 1'b1;
      expect_burst(1, 0, 4);
      start[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      chk("post_rst_issue", rom_rd[1], 1);
      wait_idle(1);
      chk("abort_no_fin", fin_cnt[1], f + 1);

      // ROM_DEPTH=4, BURST_LEN=6, RD_LAT=1.
`ifdef ROM_FETCH_WRAP_EN
      expect_burst(2, 0, 6);
      pulse(2);
      wait_idle(2);
      chk("wrap_fin", fin_cnt[2], 1);
      chk("wrap_beats", hs_cnt[2], 6);
      chk("wrap_eor_pulses", eor_cnt[2], 1);
      chk("wrap_eor_low", eor[2], 0);
      expect_burst(2, 2, 6);
      pulse(2);
      wait_idle(2);
      chk("wrap_fin2", fin_cnt[2], 2);
`else
      expect_burst(2, 0, 4);
      pulse(2);
      wait_idle(2);
      chk("stop_fin", fin_cnt[2], 1);
      chk("stop_beats", hs_cnt[2], 4);
      chk("stop_eor", eor[2], 1);
      pulse(2);
      repeat (8) tick();
      chk("locked_iss", iss_cnt[2], 4);
      chk("locked_busy", busy[2], 0);
      chk("locked_eor", eor[2], 1);
      chk("locked_fin", fin_cnt[2], 1);
`endif

      tick();
      for (int i = 0; i < N; i++) chk("sb_empty", iss_q[i].size() + beat_q[i].size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
